dmem_responder: RTL and testbench

Data-memory responder for the rvlife core: the target end of the load/store interface that execute drives as initiator. Accepts one read or write per handshake, byte-lane writes, configurable wait states, and returns a single-cycle response pulse with read data and an error flag. Sits between execute's memory port and the word-organised data array, replacing the zero-latency ram once the core tolerates stalls.

---
 rtl/rvlife_pkg.sv | 16 +
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvlife_pkg.sv
// Shared constants and state encoding for the rvlife data-memory path.
// Pure declarations: no logic, no latency.
// Imported by the responder and its storage array.
package rvlife_pkg;

  localparam int CpuWidth = 32;
  localparam int MemWidth = 32;
  localparam int BeWidth  = MemWidth / 8;

  // Responder FSM encoding; kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage, DEPTH x 32, with per-byte-lane write enables.
// Latency: write commits on the enabling edge; read data registered one edge after i_rd.
// Backpressure: none; the controlling FSM guarantees at most one access per edge.
module dmem_array
  import rvlife_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_wr,
  input  logic                       i_rd,
  input  logic                       i_clr,
  input  logic [$clog2(DEPTH)-1:0]   i_idx,
  input  logic [BeWidth-1:0]         i_be,
  input  logic [MemWidth-1:0]        i_wdata,
  output logic [MemWidth-1:0]        o_rdata
);

  logic [MemWidth-1:0] r_mem [DEPTH];
  logic [MemWidth-1:0] r_rdata;

  // Byte-lane write; storage is intentionally left unreset.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      for (int k = 0; k < BeWidth; k++) begin
        if (i_be[k]) r_mem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  // Registered read port; cleared when a response carries no read data.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rdata <= '0;
    end else if (i_rd) begin
      r_rdata <= r_mem[i_idx];
    end else if (i_clr) begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Load/store target for execute: one access per handshake, byte-lane writes, optional alignment check (DMEM_ALIGN_CHECK_EN).
// Latency: accepted at edge N -> rvalid_o in cycle N+1+WAIT_CYCLES; one transaction per WAIT_CYCLES+1 cycles.
// Backpressure: gnt_o low while waiting; initiator holds req_i and fields until granted.
module dmem_responder
  import rvlife_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [CpuWidth-1:0] addr_i,
  input  logic [MemWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]  be_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [MemWidth-1:0] rdata_o,
  output logic                err_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         HasWait  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WaitLoad = HasWait ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [CpuWidth-1:0] r_addr;
  logic [MemWidth-1:0] r_wdata;
  logic [BeWidth-1:0]  r_be;
  logic                r_err;

  logic                w_acc;
  logic                w_go_resp;
  logic                w_we;
  logic [CpuWidth-1:0] w_addr;
  logic [MemWidth-1:0] w_wdata;
  logic [BeWidth-1:0]  w_be;
  logic [AW-1:0]       w_idx;
  logic                w_oor;
  logic                w_misalign;
  logic                w_err;
  logic                w_rd;
  logic                w_wr;
  logic                w_clr;

  assign gnt_o    = (r_state != ST_WAIT);
  assign rvalid_o = (r_state == ST_RESP);
  assign w_acc    = req_i && gnt_o;

  // With no wait states a transaction enters RESP on its own acceptance edge,
  // so the array must be driven straight from the request fields; otherwise
  // from the copy latched at acceptance.
  assign w_go_resp = HasWait ? ((r_state == ST_WAIT) && (r_cnt == 4'd0)) : w_acc;
  assign w_we      = HasWait ? r_we    : we_i;
  assign w_addr    = HasWait ? r_addr  : addr_i;
  assign w_wdata   = HasWait ? r_wdata : wdata_i;
  assign w_be      = HasWait ? r_be    : be_i;

  assign w_idx = w_addr[AW+1:2];
  assign w_oor = |w_addr[CpuWidth-1:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = (w_addr[1:0] != 2'b00);
`else
  // Low address bits are don't-care: misaligned accesses fold onto their word.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^w_addr[1:0];
  assign w_misalign        = 1'b0;
`endif

  assign w_err = w_oor || w_misalign;
  assign w_rd  = w_go_resp && !w_we && !w_err;
  // Gating with rstn_i keeps a request presented during reset from writing.
  assign w_wr  = w_go_resp && w_we && !w_err && rstn_i;
  assign w_clr = w_go_resp && !w_rd;

  // Next-state decode: IDLE and RESP behave alike, both can accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      default: w_state_nxt = w_acc ? (HasWait ? ST_WAIT : ST_RESP) : ST_IDLE;
    endcase
  end

  // FSM state and wait-state counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_cnt <= WaitLoad;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Capture the request fields on acceptance; reset drops a pending access.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_acc) begin
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_be    <= be_i;
    end
  end

  // Error flag registered alongside the read data as the response forms.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err <= 1'b0;
    end else if (w_go_resp) begin
      r_err <= w_err;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (clk_i),
    .i_rstn  (rstn_i),
    .i_wr    (w_wr),
    .i_rd    (w_rd),
    .i_clr   (w_clr),
    .i_idx   (w_idx),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (rdata_o)
  );

  assign err_o = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) against a word-array model.
// Directed cases from the test plan, then randomized reads/writes incl. out-of-range and misaligned.
// Responses are timed in cycles from the acceptance edge.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int WC0 = 0;
  localparam int WC1 = 3;

  logic        clk;
  logic        rstn;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [31:0] mdl [2][1024];
  int vec_cnt = 0;
  int err_cnt = 0;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(WC0)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(WC1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Memory model: word index is the byte address divided by four.
  task automatic model(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, output logic [31:0] rd, output bit er);
    int unsigned wi;
    wi = a / 4;
    er = (a >= 32'd4096) || (ALIGN && (a % 4 != 0));
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int k = 0; k < 4; k++) begin
          if (b[k]) mdl[d][wi][8*k +: 8] = wd[8*k +: 8];
        end
      end else begin
        rd = mdl[d][wi];
      end
    end
  endtask

  // One complete transaction; called and returns just after a negedge.
  task automatic run(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, output logic [31:0] got_rd, output logic got_er);
    logic [31:0] exp_rd;
    bit          exp_er;
    int          n;
    int          lat;
    model(d, w, a, wd, b, exp_rd, exp_er);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    n = 0;
    while (gnt[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("gnt_timeout", 32'(gnt[d]), 32'h1);
    @(posedge clk);
    #1 req[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rvalid[d] !== 1'b1 && lat < 30);
    chk("latency", 32'(lat), 32'(1 + ((d == 0) ? WC0 : WC1)));
    got_rd = rdata[d];
    got_er = err[d];
    chk("rdata", rdata[d], exp_rd);
    chk("err", 32'(err[d]), 32'(exp_er));
    @(negedge clk);
    chk("rvalid_pulse", 32'(rvalid[d]), 32'h0);
  endtask

  initial begin : main
    logic [31:0] rd;
    logic [31:0] md;
    logic        er;
    bit          me;
    int          cnt;
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; wdata[d] = 0; be[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rvalid", 32'(rvalid[d]), 32'h0);
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_err", 32'(err[d]), 32'h0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt[0]), 32'h1);
    chk("rst_gnt1", 32'(gnt[1]), 32'h1);

    // Basic write/read, zero wait states.
    run(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
    chk("wr_rdata_zero", rd, 32'h0);
    run(0, 0, 32'h10, 32'h0, 4'hF, rd, er);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // Byte lanes.
    run(0, 1, 32'h20, 32'h11223344, 4'hF, rd, er);
    run(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er);
    run(0, 0, 32'h20, 32'h0, 4'h0, rd, er);
    chk("byte_lanes", rd, 32'h11BB33DD);
    run(0, 1, 32'h20, 32'h99999999, 4'h0, rd, er);
    chk("be0_err", 32'(er), 32'h0);
    run(0, 0, 32'h20, 32'h0, 4'hF, rd, er);
    chk("be0_noop", rd, 32'h11BB33DD);

    // Out of range.
    run(0, 1, 32'h0, 32'h01020304, 4'hF, rd, er);
    run(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er);
    chk("oor_wr_err", 32'(er), 32'h1);
    run(0, 0, 32'h0, 32'h0, 4'hF, rd, er);
    chk("oor_word0", rd, 32'h01020304);
    run(0, 0, 32'h1000, 32'h0, 4'hF, rd, er);
    chk("oor_rd_data", rd, 32'h0);
    chk("oor_rd_err", 32'(er), 32'h1);

    // Misaligned read.
    run(0, 0, 32'h22, 32'h0, 4'hF, rd, er);
    chk("mis_rdata", rd, ALIGN ? 32'h0 : 32'h11BB33DD);
    chk("mis_err", 32'(er), ALIGN ? 32'h1 : 32'h0);

    // Back-to-back write then read of the same word.
    model(0, 1, 32'h44, 32'hCAFE0123, 4'hF, md, me);
    req[0] = 1; we[0] = 1; addr[0] = 32'h44; wdata[0] = 32'hCAFE0123; be[0] = 4'hF;
    @(posedge clk);
    #1 we[0] = 1'b0;
    @(negedge clk);
    chk("b2b_wr_rvalid", 32'(rvalid[0]), 32'h1);
    chk("b2b_wr_gnt", 32'(gnt[0]), 32'h1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    chk("b2b_rd_rvalid", 32'(rvalid[0]), 32'h1);
    chk("b2b_rd_data", rdata[0], 32'hCAFE0123);
    @(negedge clk);
    chk("b2b_idle", 32'(rvalid[0]), 32'h0);

    // Three wait states with req held through the wait.
    run(1, 1, 32'h10, 32'h0BADF00D, 4'hF, rd, er);
    req[1] = 1; we[1] = 0; addr[1] = 32'h10; be[1] = 4'hF;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("wait_gnt_low", 32'(gnt[1]), 32'h0);
      chk("wait_no_rvalid", 32'(rvalid[1]), 32'h0);
    end
    @(negedge clk);
    chk("wait_rvalid", 32'(rvalid[1]), 32'h1);
    chk("wait_resp_gnt", 32'(gnt[1]), 32'h1);
    chk("wait_rdata", rdata[1], 32'h0BADF00D);
    req[1] = 1'b0;
    @(negedge clk);
    chk("wait_single", 32'(rvalid[1]), 32'h0);
    chk("wait_idle_gnt", 32'(gnt[1]), 32'h1);

    // Reset during the wait of a write.
    run(1, 1, 32'h30, 32'h5A5A1234, 4'hF, rd, er);
    req[1] = 1; we[1] = 1; addr[1] = 32'h30; wdata[1] = 32'hFFFF0000; be[1] = 4'hF;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_mid_gnt", 32'(gnt[1]), 32'h1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rvalid[1] === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("rst_mid_no_rvalid", 32'(cnt), 32'h0);
    run(1, 0, 32'h30, 32'h0, 4'hF, rd, er);
    chk("rst_mid_prior", rd, 32'h5A5A1234);

    // Randomized traffic over a preloaded window of 16 words.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) run(d, 1, 32'(w * 4), $urandom, 4'hF, rd, er);
    end
    for (int i = 0; i < 200; i++) begin
      int          d;
      logic [31:0] a;
      d = i % 2;
      if ($urandom_range(0, 7) == 0) a = $urandom_range(32'h1000, 32'h7FFFFFFF);
      else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      run(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
